// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the bus master controller slice: controller node
// ID, node ID constants, header field positions, default grant wait and the
// controller FSM state encoding. Includes a helper to build a header byte.
package bus_pkg;

    // Node IDs; the controller owns CTRL_ID so it is never a valid source.
    localparam logic [1:0] CTRL_ID = 2'b11;
    localparam logic [1:0] NODE_0  = 2'b00;
    localparam logic [1:0] NODE_1  = 2'b01;
    localparam logic [1:0] NODE_2  = 2'b10;

    // Header byte layout: [7:6] zero, [5:4] dst, [3:2] src, [1:0] op.
    localparam int unsigned HDR_OP_LSB  = 0;
    localparam int unsigned HDR_SRC_LSB = 2;
    localparam int unsigned HDR_DST_LSB = 4;

    localparam int unsigned GRANT_WAIT_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_GRANT = 3'd2,
        ST_XFER  = 3'd3,
        ST_ACK   = 3'd4
    } bus_state_e;

    function automatic logic [7:0] make_header(input logic [1:0] dst,
                                               input logic [1:0] src,
                                               input logic [1:0] op);
        logic [7:0] h;
        h = '0;
        h[HDR_DST_LSB +: 2] = dst;
        h[HDR_SRC_LSB +: 2] = src;
        h[HDR_OP_LSB  +: 2] = op;
        return h;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog
// Idle-cycle counter for the payload phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reset the idle count (beat seen, or not in payload phase)
//   tick       : one idle payload cycle
//   expired    : this tick brings the idle count to TIMEOUT
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (clear) begin
            idle_cnt <= '0;
        end else if (tick && (idle_cnt != CW'(TIMEOUT))) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Flag the tick that completes the TIMEOUT-th idle cycle so the
    // controller can leave the payload phase on that same edge.
    assign expired = tick && !clear && (idle_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl
// Shared-bus transfer controller. Accepts a request, drives a one-cycle
// header onto the bus, waits GRANT_WAIT cycles, then counts payload beats
// driven by the source node until the requested length or an idle timeout,
// and finally reports completion with a one-cycle ack/done pulse.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_src/req_dst/req_op/req_len   : request fields (len 0 means 256)
//   bus_data_o/bus_valid_o/bus_oe    : header drive and tri-state enable
//   bus_data_i/bus_valid_i           : sampled shared bus
//   ack                              : end-of-transfer broadcast pulse
//   busy                             : controller not idle
//   done_valid/done_err/done_count   : completion report
module bus_master_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned GRANT_WAIT = GRANT_WAIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_src,
    input  logic [1:0] req_dst,
    input  logic [1:0] req_op,
    input  logic [7:0] req_len,
    output logic [7:0] bus_data_o,
    output logic       bus_valid_o,
    output logic       bus_oe,
    input  logic [7:0] bus_data_i,
    input  logic       bus_valid_i,
    output logic       ack,
    output logic       busy,
    output logic       done_valid,
    output logic       done_err,
    output logic [8:0] done_count
);

    localparam int unsigned GW_W = (GRANT_WAIT > 1) ? $clog2(GRANT_WAIT) : 1;
    localparam logic [GW_W-1:0] GW_LAST = GW_W'((GRANT_WAIT > 0) ? GRANT_WAIT - 1 : 0);

    bus_state_e      state;
    logic [8:0]      len_eff;
    logic [8:0]      beat_cnt;
    logic [8:0]      beat_next;
    logic [GW_W-1:0] grant_cnt;
    logic            err_flag;
    logic            wd_clear;
    logic            wd_tick;
    logic            wd_expired;
    logic            req_bad;

    // Payload bytes travel source-to-destination directly; the controller
    // only counts beats, so the sampled data is intentionally not consumed.
    logic unused_bus_data;
    assign unused_bus_data = ^bus_data_i;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign beat_next = beat_cnt + 9'd1;
    assign req_bad   = (req_src == req_dst) || (req_src == CTRL_ID);

    assign wd_clear  = (state != ST_XFER) || bus_valid_i;
    assign wd_tick   = (state == ST_XFER) && !bus_valid_i;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_eff     <= '0;
            beat_cnt    <= '0;
            grant_cnt   <= '0;
            err_flag    <= 1'b0;
            bus_data_o  <= '0;
            bus_valid_o <= 1'b0;
            bus_oe      <= 1'b0;
            ack         <= 1'b0;
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
            done_count  <= '0;
        end else begin
            // Pulse outputs default low; bus drive only exists in HDR.
            ack         <= 1'b0;
            done_valid  <= 1'b0;
            bus_oe      <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_data_o  <= '0;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                            done_count <= '0;
                        end else begin
                            state       <= ST_HDR;
                            bus_oe      <= 1'b1;
                            bus_valid_o <= 1'b1;
                            bus_data_o  <= make_header(req_dst, req_src, req_op);
                            len_eff     <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                            beat_cnt    <= '0;
                            err_flag    <= 1'b0;
                        end
                    end
                end

                // Our own header echoes back on bus_valid_i; not sampled here.
                ST_HDR: begin
                    grant_cnt <= '0;
                    state     <= (GRANT_WAIT == 0) ? ST_XFER : ST_GRANT;
                end

                ST_GRANT: begin
                    if (bus_valid_i) begin
                        err_flag <= 1'b1;
                    end
                    if (grant_cnt == GW_LAST) begin
                        state <= ST_XFER;
                    end else begin
                        grant_cnt <= grant_cnt + 1'b1;
                    end
                end

                ST_XFER: begin
                    if (bus_valid_i) begin
                        beat_cnt <= beat_next;
                        if (beat_next == len_eff) begin
                            state      <= ST_ACK;
                            ack        <= 1'b1;
                            done_valid <= 1'b1;
                            done_err   <= err_flag;
                            done_count <= beat_next;
                        end
                    end else if (wd_expired) begin
                        state      <= ST_ACK;
                        ack        <= 1'b1;
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        done_count <= beat_cnt;
                    end
                end

                ST_ACK: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl
// Directed bench for bus_master_ctrl. Each transfer pushes its expected
// header and completion record into queues; a negedge monitor pops and
// compares whenever the DUT drives the bus or reports completion.
module tb_bus_master_ctrl;

    localparam int GW = 3;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_dst;
    logic [1:0] req_op;
    logic [7:0] req_len;
    logic [7:0] bus_data_o;
    logic       bus_valid_o;
    logic       bus_oe;
    logic [7:0] bus_data_i;
    logic       bus_valid_i;
    logic       ack;
    logic       busy;
    logic       done_valid;
    logic       done_err;
    logic [8:0] done_count;

    bus_master_ctrl #(
        .TIMEOUT    (16),
        .GRANT_WAIT (GW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_op      (req_op),
        .req_len     (req_len),
        .bus_data_o  (bus_data_o),
        .bus_valid_o (bus_valid_o),
        .bus_oe      (bus_oe),
        .bus_data_i  (bus_data_i),
        .bus_valid_i (bus_valid_i),
        .ack         (ack),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_err    (done_err),
        .done_count  (done_count)
    );

    typedef struct {
        logic     err;
        int       count;
        logic     ack;
        int       acc_cyc;
        int       lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hdr_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus drive and completion reports.
    always @(negedge clk) begin
        if (bus_oe) begin
            if (hdr_q.size() == 0) begin
                check("unexpected_bus_oe", 32'd1, 32'd0);
            end else begin
                logic [7:0] h;
                h = hdr_q.pop_front();
                check("hdr_data", {24'd0, bus_data_o}, {24'd0, h});
                check("hdr_valid", {31'd0, bus_valid_o}, 32'd1);
                check("hdr_busy", {31'd0, busy}, 32'd1);
            end
        end else if (bus_valid_o || bus_data_o != 8'd0) begin
            check("bus_idle_drive", {23'd0, bus_valid_o, bus_data_o}, 32'd0);
        end

        if (done_valid || ack) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {30'd0, ack, done_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_valid", {31'd0, done_valid}, 32'd1);
                check("done_ack", {31'd0, ack}, {31'd0, e.ack});
                check("done_err", {31'd0, done_err}, {31'd0, e.err});
                check("done_count", {23'd0, done_count}, e.count);
                check("done_latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0 || hdr_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d done / %0d header expectations still pending, expected 0",
                     sb.size(), hdr_q.size());
            sb.delete();
            hdr_q.delete();
        end
    endtask

    // One directed transfer. Accepted on the first edge with req_valid high.
    task automatic run_xfer(input logic [1:0] src, input logic [1:0] dst,
                            input logic [1:0] op, input logic [7:0] len,
                            input logic hdr_echo, input logic grant_beat,
                            input int nbeats, input logic [7:0] exp_hdr,
                            input logic rej, input logic exp_err,
                            input int exp_cnt, input int exp_lat);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_src   = src;
        req_dst   = dst;
        req_op    = op;
        req_len   = len;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e.err     = exp_err;
        e.count   = exp_cnt;
        e.ack     = !rej;
        e.acc_cyc = cyc;
        e.lat     = exp_lat;
        if (!rej) hdr_q.push_back(exp_hdr);
        sb.push_back(e);
        if (!rej) begin
            bus_valid_i = hdr_echo;
            for (int i = 0; i < GW; i++) begin
                @(posedge clk); #1;
                bus_valid_i = (i == 0) && grant_beat;
            end
            @(posedge clk); #1;
            for (int n = 0; n < nbeats; n++) begin
                bus_valid_i = 1'b1;
                bus_data_i  = 8'(n);
                @(posedge clk); #1;
            end
            bus_valid_i = 1'b0;
        end
        wait_drain(400);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_src     = '0;
        req_dst     = '0;
        req_op      = '0;
        req_len     = '0;
        bus_data_i  = '0;
        bus_valid_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_done_valid", {31'd0, done_valid}, 32'd0);
        check("rst_done_err", {31'd0, done_err}, 32'd0);
        check("rst_done_count", {23'd0, done_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // src dst op len echo gbeat nbeats hdr rej err cnt lat
        run_xfer(2'd0, 2'd1, 2'd2, 8'd4, 1'b0, 1'b0, 4,   8'h12, 1'b0, 1'b0, 4,   8);
        run_xfer(2'd1, 2'd1, 2'd0, 8'd4, 1'b0, 1'b0, 0,   8'h00, 1'b1, 1'b1, 0,   0);
        run_xfer(2'd3, 2'd0, 2'd1, 8'd2, 1'b0, 1'b0, 0,   8'h00, 1'b1, 1'b1, 0,   0);
        run_xfer(2'd0, 2'd2, 2'd1, 8'd3, 1'b0, 1'b0, 2,   8'h21, 1'b0, 1'b1, 2,   22);
        run_xfer(2'd1, 2'd0, 2'd3, 8'd0, 1'b0, 1'b0, 256, 8'h07, 1'b0, 1'b0, 256, 260);
        run_xfer(2'd2, 2'd1, 2'd0, 8'd2, 1'b0, 1'b1, 2,   8'h18, 1'b0, 1'b1, 2,   6);
        run_xfer(2'd2, 2'd0, 2'd1, 8'd1, 1'b1, 1'b0, 1,   8'h09, 1'b0, 1'b0, 1,   5);

        // Reset during the second payload beat.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_src   = 2'd0;
        req_dst   = 2'd2;
        req_op    = 2'd3;
        req_len   = 8'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        hdr_q.push_back(8'h23);
        for (int i = 0; i < GW; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_valid_i = 1'b1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done_valid", {31'd0, done_valid}, 32'd0);
        check("midrst_done_count", {23'd0, done_count}, 32'd0);
        bus_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("postrst_hdr_consumed", hdr_q.size(), 32'd0);

        run_xfer(2'd1, 2'd2, 2'd1, 8'd3, 1'b0, 1'b0, 3,   8'h25, 1'b0, 1'b0, 3,   7);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_ctrl.md
BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: idle cycles allowed between payload beats before abort.
REQ-002 Parameter GRANT_WAIT, default 3: cycles between header and source's first permitted beat.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  transfer request present.
REQ-006 req_ready  output  1  controller accepts request this cycle.
REQ-007 req_src  input  2  source node ID.
REQ-008 req_dst  input  2  destination node ID.
REQ-009 req_op  input  2  opcode, copied into header.
REQ-010 req_len  input  8  payload beats; 0 means 256.
REQ-011 bus_data_o  output  8  byte driven onto shared bus.
REQ-012 bus_valid_o  output  1  valid driven onto shared bus.
REQ-013 bus_oe  output  1  enable for top-level tri-state drivers of bus_data/bus_valid.
REQ-014 bus_data_i  input  8  shared bus data, sampled.
REQ-015 bus_valid_i  input  1  shared bus valid, sampled.
REQ-016 ack  output  1  end-of-transfer pulse, broadcast to all nodes.
REQ-017 busy  output  1  state != IDLE.
REQ-018 done_valid  output  1  one-cycle completion pulse.
REQ-019 done_err  output  1  completion error flag, valid with done_valid.
REQ-020 done_count  output  9  payload beats observed, valid with done_valid.

Function
REQ-021 The FSM SHALL have states IDLE, HDR, GRANT, XFER, ACK.
REQ-022 req_ready SHALL be 1 only in IDLE; request accepted on req_valid && req_ready; fields latched.
REQ-023 On acceptance with req_src==req_dst or req_src==2'b11, the controller SHALL stay IDLE and pulse done_valid, done_err=1, done_count=0 next cycle, with no bus activity.
REQ-024 Otherwise, IDLE->HDR: for exactly one cycle bus_oe=1, bus_valid_o=1, bus_data_o={2'b00, dst, src, op} (bits 7:6 zero, 5:4 dst, 3:2 src, 1:0 op).
REQ-025 HDR->GRANT: bus_oe=0 for GRANT_WAIT cycles; bus_valid_i beats in GRANT SHALL be counted as errors (done_err=1 at completion) but not as payload.
REQ-026 GRANT->XFER: each cycle with bus_valid_i=1 SHALL increment beat counter (9 bits); idle counter resets to 0 on each beat, else increments.
REQ-027 When beat counter reaches effective length (1..256), FSM SHALL enter ACK on the next edge; beat sampled in same cycle as final count is the last one counted.
REQ-028 When idle counter reaches TIMEOUT in XFER, FSM SHALL enter ACK with error set.
REQ-029 In ACK (one cycle): ack=1, done_valid=1, done_err and done_count reported; then IDLE.
REQ-030 bus_oe SHALL be 0 in all states except HDR; bus_data_o=0 and bus_valid_o=0 whenever bus_oe=0.
REQ-031 ack, done_valid SHALL never be asserted outside the ACK cycle or REQ-023 reject cycle.
REQ-032 bus_valid_i during HDR (own header) SHALL be ignored.

Reset
REQ-033 Asserting rst_n low SHALL immediately force IDLE, bus_oe=0, bus_valid_o=0, bus_data_o=0, ack=0, busy=0, done_valid=0, done_err=0, done_count=0, counters 0; req_ready=1 after release.
REQ-034 Reset mid-transfer SHALL NOT emit ack; nodes recover on their own reset.

Structure
REQ-035 Shared package bus_pkg SHALL hold CTRL_ID=2'b11, header field positions, node ID constants, default GRANT_WAIT and FSM state encoding.
REQ-036 One sub-module bus_watchdog SHALL implement the idle counter and timeout flag (inputs: clear, tick; output: expired).

Verification
REQ-037 src=0,dst=1,op=2,len=4; source drives 4 beats from first XFER cycle -> header 0x12 one cycle, ack at 4th beat +1, done_count=4, done_err=0.
REQ-038 src=1,dst=1 -> no bus_oe, done_valid with done_err=1, done_count=0 next cycle.
REQ-039 len=3, 2 beats then silence -> ack after 16 idle cycles, done_err=1, done_count=2.
REQ-040 len=0, 256 continuous beats -> done_count=256, done_err=0.
REQ-041 Beat during GRANT then 2 beats with len=2 -> done_err=1, done_count=2.
REQ-042 rst_n low at 2nd XFER beat -> bus_oe, ack, busy 0 immediately; new request accepted after release.
